// File: rtl/vga_compositor.sv
// vga_compositor: programmable VGA timing generator with an N-layer,
// priority-ordered colour compositor. Colour sets are shadowed per frame.
module vga_compositor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LAYERS   = 4,
  parameter int COLOR_W  = 4,
  parameter int PX_LAT   = 1
) (
  input  logic                            vga_clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [LAYERS-1:0]               px_layer,
  input  logic [LAYERS*3*COLOR_W-1:0]     layer_rgb,
  input  logic [3*COLOR_W-1:0]            bg_rgb,
  output logic [$clog2(V_ACTIVE)-1:0]     row_addr,
  output logic [$clog2(H_ACTIVE)-1:0]     col_addr,
  output logic                            addr_valid,
  output logic [COLOR_W-1:0]              r,
  output logic [COLOR_W-1:0]              g,
  output logic [COLOR_W-1:0]              b,
  output logic                            de,
  output logic                            hs,
  output logic                            vs,
  output logic                            frame_start,
  output logic [15:0]                     frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  // One spare bit of headroom so the active-end compare never overflows.
  localparam int HCW  = $clog2(H_TOTAL + 1);
  localparam int VCW  = $clog2(V_TOTAL + 1);
  localparam int RW   = $clog2(V_ACTIVE);
  localparam int CW   = $clog2(H_ACTIVE);
  localparam int CRGB = 3 * COLOR_W;
  localparam int DW   = 3 * (PX_LAT + 1);

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_SE   = HCW'(H_SYNC);
  localparam logic [HCW-1:0] H_AS   = HCW'(H_SYNC + H_BP);
  localparam logic [HCW-1:0] H_AE   = HCW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_SE   = VCW'(V_SYNC);
  localparam logic [VCW-1:0] V_AS   = VCW'(V_SYNC + V_BP);
  localparam logic [VCW-1:0] V_AE   = VCW'(V_SYNC + V_BP + V_ACTIVE);

  // Delay-line element is {de, hs, vs}; idle means blanked with syncs inactive.
  localparam logic [2:0] DLY_IDLE = {1'b0, ~HS_POL, ~VS_POL};

  logic [HCW-1:0]       h_count_q, h_count_d;
  logic [VCW-1:0]       v_count_q, v_count_d;
  logic                 h_act, v_act, pix_act, hs_lvl, vs_lvl, fs_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 addr_valid_q, frame_start_q;
  logic [15:0]          frame_cnt_q;
  logic [DW-1:0]        dly_q, dly_d;
  logic [2:0]           dly_out;
  logic [LAYERS*CRGB-1:0] layer_sh_q;
  logic [CRGB-1:0]      bg_sh_q;
  logic [CRGB-1:0]      layer_col [LAYERS];
  logic [CRGB-1:0]      rgb_q, rgb_d;
  logic                 de_q, hs_q, vs_q;

  // Next-state of the raster counters; everything freezes while en is low.
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (en) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 1'b1;
      end else begin
        h_count_d = h_count_q + 1'b1;
      end
    end
  end

  // Raster counters.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  // Region decode and stage-A next values; a frozen raster feeds blank pixels.
  always_comb begin
    h_act   = (h_count_q >= H_AS) && (h_count_q < H_AE);
    v_act   = (v_count_q >= V_AS) && (v_count_q < V_AE);
    pix_act = h_act && v_act && en;
    hs_lvl  = (h_count_q < H_SE) ? HS_POL : ~HS_POL;
    vs_lvl  = (v_count_q < V_SE) ? VS_POL : ~VS_POL;
    fs_d    = en && (h_count_q == H_AS) && (v_count_q == V_AS);
    row_d   = '0;
    col_d   = '0;
    if (pix_act) begin
      row_d = RW'(v_count_q - V_AS);
      col_d = CW'(h_count_q - H_AS);
    end
    dly_d      = dly_q << 3;
    dly_d[2:0] = {pix_act, hs_lvl, vs_lvl};
  end

  // Stage A: addresses, frame marker, frame counter and the sync/de delay line.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      row_q         <= '0;
      col_q         <= '0;
      addr_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      dly_q         <= {(PX_LAT + 1){DLY_IDLE}};
    end else begin
      row_q         <= row_d;
      col_q         <= col_d;
      addr_valid_q  <= pix_act;
      frame_start_q <= fs_d;
      dly_q         <= dly_d;
      if (fs_d) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Colour shadows load on the edge that raises frame_start, so even the
  // first pixel of a frame (reaching stage B one clock later at PX_LAT=0)
  // already uses the new set.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      layer_sh_q <= '0;
      bg_sh_q    <= '0;
    end else if (fs_d) begin
      layer_sh_q <= layer_rgb;
      bg_sh_q    <= bg_rgb;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LAYERS; gi++) begin : g_layer
      assign layer_col[gi] = layer_sh_q[gi*CRGB +: CRGB];
    end
  endgenerate

  // Priority select: lowest-index hit wins, background otherwise, black in blanking.
  always_comb begin
    dly_out = dly_q[3*PX_LAT +: 3];
    rgb_d   = bg_sh_q;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (px_layer[i]) begin
        rgb_d = layer_col[i];
      end
    end
    if (!dly_out[2]) begin
      rgb_d = '0;
    end
  end

  // Stage B: pin registers, keeping rgb/de/hs/vs mutually aligned.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
    end else begin
      rgb_q <= rgb_d;
      de_q  <= dly_out[2];
      hs_q  <= dly_out[1];
      vs_q  <= dly_out[0];
    end
  end

  assign row_addr    = row_q;
  assign col_addr    = col_q;
  assign addr_valid  = addr_valid_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign r           = rgb_q[CRGB-1 -: COLOR_W];
  assign g           = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign b           = rgb_q[COLOR_W-1:0];
  assign de          = de_q;
  assign hs          = hs_q;
  assign vs          = vs_q;

endmodule

// File: tb/tb_vga_compositor.sv
// Directed bench: default-geometry DUT plus two tiny-geometry DUTs (PX_LAT 0 and 3).
module tb_vga_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  px_layer;
  logic [47:0] layer_rgb;
  logic [11:0] bg_rgb;

  always #5 clk = ~clk;

  // Default-geometry DUT outputs
  logic [8:0]  d_row;
  logic [9:0]  d_col;
  logic        d_av, d_de, d_hs, d_vs, d_fs;
  logic [3:0]  d_r, d_g, d_b;
  logic [15:0] d_fc;
  // Small geometry, PX_LAT=0
  logic [1:0]  s0_row;
  logic [2:0]  s0_col;
  logic        s0_av, s0_de, s0_hs, s0_vs, s0_fs;
  logic [3:0]  s0_r, s0_g, s0_b;
  logic [15:0] s0_fc;
  // Small geometry, PX_LAT=3
  logic [1:0]  s3_row;
  logic [2:0]  s3_col;
  logic        s3_av, s3_de, s3_hs, s3_vs, s3_fs;
  logic [3:0]  s3_r, s3_g, s3_b;
  logic [15:0] s3_fc;

  vga_compositor dut (
    .vga_clk(clk), .rst(rst), .en(en), .px_layer(px_layer),
    .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .row_addr(d_row), .col_addr(d_col), .addr_valid(d_av),
    .r(d_r), .g(d_g), .b(d_b), .de(d_de), .hs(d_hs), .vs(d_vs),
    .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_compositor #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PX_LAT(0)
  ) dut_s0 (
    .vga_clk(clk), .rst(rst), .en(en), .px_layer(px_layer),
    .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .row_addr(s0_row), .col_addr(s0_col), .addr_valid(s0_av),
    .r(s0_r), .g(s0_g), .b(s0_b), .de(s0_de), .hs(s0_hs), .vs(s0_vs),
    .frame_start(s0_fs), .frame_cnt(s0_fc)
  );

  vga_compositor #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PX_LAT(3)
  ) dut_s3 (
    .vga_clk(clk), .rst(rst), .en(en), .px_layer(px_layer),
    .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .row_addr(s3_row), .col_addr(s3_col), .addr_valid(s3_av),
    .r(s3_r), .g(s3_g), .b(s3_b), .de(s3_de), .hs(s3_hs), .vs(s3_vs),
    .frame_start(s3_fs), .frame_cnt(s3_fc)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Clock index since reset release: raster counters hold (cyc mod H_TOTAL) etc.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @clk%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance to the falling edge of clock index n (never waits on the DUT).
  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  int s0_hs_lo, s0_vs_lo, s0_de_hi, s3_hs_lo, s3_vs_lo, s3_de_hi, s0_hs_line;
  int d_hs_lo, d_vs_lo, d_de_hi;

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    px_layer  = 4'b0110;
    layer_rgb = {12'hFFF, 12'h0F0, 12'hF00, 12'h00F};
    bg_rgb    = 12'h123;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_d_hs", 32'(d_hs), 32'd1);
    chk("rst_d_vs", 32'(d_vs), 32'd1);
    chk("rst_d_de", 32'(d_de), 32'd0);
    chk("rst_d_rgb", 32'({d_r, d_g, d_b}), 32'h0);
    chk("rst_d_av", 32'(d_av), 32'd0);
    chk("rst_d_fc", 32'(d_fc), 32'd0);
    chk("rst_s3_hs", 32'(s3_hs), 32'd1);
    rst = 1'b0;

    // ---------------- small geometry: H_TOTAL 14, V_TOTAL 7, frame 98 clocks
    goto(32);  chk("s0_av_pre", 32'(s0_av), 32'd0);
    goto(33);
    chk("s0_av_first", 32'(s0_av), 32'd1);
    chk("s0_fs_first", 32'(s0_fs), 32'd1);
    chk("s0_addr_first", 32'({s0_row, s0_col}), 32'd0);
    chk("s0_fc1", 32'(s0_fc), 32'd1);
    chk("s3_fc1", 32'(s3_fc), 32'd1);
    chk("s0_de_pre", 32'(s0_de), 32'd0);
    goto(34);
    chk("s0_de_first", 32'(s0_de), 32'd1);
    chk("s0_rgb_prio", 32'({s0_r, s0_g, s0_b}), 32'hF00);
    chk("s0_fs_pulse", 32'(s0_fs), 32'd0);
    goto(36);  chk("s3_de_pre", 32'(s3_de), 32'd0);
    goto(37);
    chk("s3_de_first", 32'(s3_de), 32'd1);
    chk("s3_rgb_prio", 32'({s3_r, s3_g, s3_b}), 32'hF00);
    goto(130); chk("s0_fs_gap", 32'(s0_fs), 32'd0);
    goto(131);
    chk("s0_fs_f1", 32'(s0_fs), 32'd1);
    chk("s0_fc2", 32'(s0_fc), 32'd2);

    s0_hs_lo = 0; s0_vs_lo = 0; s0_de_hi = 0; s0_hs_line = 0;
    s3_hs_lo = 0; s3_vs_lo = 0; s3_de_hi = 0;
    for (int c = 200; c < 298; c++) begin
      goto(c);
      if (!s0_hs) s0_hs_lo++;
      if (!s0_vs) s0_vs_lo++;
      if (s0_de)  s0_de_hi++;
      if (!s3_hs) s3_hs_lo++;
      if (!s3_vs) s3_vs_lo++;
      if (s3_de)  s3_de_hi++;
      if (c < 214 && !s0_hs) s0_hs_line++;
      if (c == 250) layer_rgb[23:12] = 12'h0AA;
      if (c == 260) chk("s0_midframe_hold", 32'({s0_r, s0_g, s0_b}), 32'hF00);
      if (c == 282) chk("s3_midframe_hold", 32'({s3_r, s3_g, s3_b}), 32'hF00);
    end
    chk("s0_hs_per_line", 32'(s0_hs_line), 32'd2);
    chk("s0_hs_per_frame", 32'(s0_hs_lo), 32'd14);
    chk("s0_vs_per_frame", 32'(s0_vs_lo), 32'd14);
    chk("s0_de_per_frame", 32'(s0_de_hi), 32'd32);
    chk("s3_hs_per_frame", 32'(s3_hs_lo), 32'd14);
    chk("s3_vs_per_frame", 32'(s3_vs_lo), 32'd14);
    chk("s3_de_per_frame", 32'(s3_de_hi), 32'd32);

    goto(327);
    chk("s0_blank_de", 32'(s0_de), 32'd0);
    chk("s0_blank_rgb", 32'({s0_r, s0_g, s0_b}), 32'h0);
    goto(328); chk("s0_newcolour", 32'({s0_r, s0_g, s0_b}), 32'h0AA);
    goto(330); chk("s3_blank_rgb", 32'({s3_r, s3_g, s3_b}), 32'h0);
    goto(331); chk("s3_newcolour", 32'({s3_r, s3_g, s3_b}), 32'h0AA);

    goto(340); px_layer = 4'b0000;
    goto(344); chk("s0_bg", 32'({s0_r, s0_g, s0_b}), 32'h123);
    goto(350); px_layer = 4'b1001;
    goto(356); chk("s0_layer0", 32'({s0_r, s0_g, s0_b}), 32'h00F);
    goto(360); px_layer = 4'b0100;
    goto(362); chk("s0_layer2", 32'({s0_r, s0_g, s0_b}), 32'h0F0);
    goto(370); px_layer = 4'b0110; layer_rgb[23:12] = 12'hF00;

    goto(380);
    force dut_s3.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_s3.frame_cnt_q;
    goto(424); chk("s3_fc_preload", 32'(s3_fc), 32'hFFFF);
    goto(425);
    chk("s3_fc_wrap", 32'(s3_fc), 32'h0);
    chk("s0_fc5", 32'(s0_fc), 32'd5);

    // Asynchronous reset in the middle of an active line
    goto(440);
    chk("s0_de_before_rst", 32'(s0_de), 32'd1);
    chk("s0_av_before_rst", 32'(s0_av), 32'd1);
    chk("s0_rgb_before_rst", 32'({s0_r, s0_g, s0_b}), 32'hF00);
    chk("s3_hs_before_rst", 32'(s3_hs), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_s0_de", 32'(s0_de), 32'd0);
    chk("async_s0_av", 32'(s0_av), 32'd0);
    chk("async_s0_rgb", 32'({s0_r, s0_g, s0_b}), 32'h0);
    chk("async_s3_hs", 32'(s3_hs), 32'd1);
    chk("async_d_vs", 32'(d_vs), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("post_rst_s0_fc", 32'(s0_fc), 32'd0);

    // ---------------- default geometry, counted from the new release
    d_hs_lo = 0; d_vs_lo = 0;
    for (int c = 0; c < 2000; c++) begin
      goto(c);
      if (c == 2) chk("d_hs_latency_pre", 32'(d_hs), 32'd1);
      if (c == 3) begin
        chk("d_hs_latency", 32'(d_hs), 32'd0);
        chk("d_vs_latency", 32'(d_vs), 32'd0);
      end
      if (c >= 3 && c < 803 && !d_hs) d_hs_lo++;
      if (!d_vs) d_vs_lo++;
    end
    chk("d_hs_low_per_line", 32'(d_hs_lo), 32'd96);
    chk("d_vs_low_2_lines", 32'(d_vs_lo), 32'd1600);

    goto(28144); chk("d_av_pre", 32'(d_av), 32'd0);
    goto(28145);
    chk("d_av_first", 32'(d_av), 32'd1);
    chk("d_addr_first", 32'({d_row, d_col}), 32'd0);
    chk("d_fs_first", 32'(d_fs), 32'd1);
    chk("d_fc1", 32'(d_fc), 32'd1);
    goto(28146);
    chk("d_fs_pulse", 32'(d_fs), 32'd0);
    chk("d_col1", 32'(d_col), 32'd1);
    chk("d_de_pre", 32'(d_de), 32'd0);
    d_de_hi = 0;
    for (int c = 28147; c < 28947; c++) begin
      goto(c);
      if (d_de) d_de_hi++;
      if (c == 28147) begin
        chk("d_de_first", 32'(d_de), 32'd1);
        chk("d_rgb_prio", 32'({d_r, d_g, d_b}), 32'hF00);
      end
      if (c == 28300) px_layer = 4'b0000;
      if (c == 28302) chk("d_bg", 32'({d_r, d_g, d_b}), 32'h123);
      if (c == 28320) px_layer = 4'b0110;
      if (c == 28800) begin
        chk("d_porch_de", 32'(d_de), 32'd0);
        chk("d_porch_rgb", 32'({d_r, d_g, d_b}), 32'h0);
      end
      if (c == 28945) chk("d_row1", 32'({d_av, d_row, d_col}), 32'({1'b1, 9'd1, 10'd0}));
    end
    chk("d_de_per_line", 32'(d_de_hi), 32'd640);

    // Jump the raster to the last active line to reach the final address
    goto(29000);
    force dut.v_count_q = 10'd514;
    @(negedge clk);
    release dut.v_count_q;
    goto(29583); chk("d_col638", 32'(d_col), 32'd638);
    goto(29584); chk("d_addr_last", 32'({d_av, d_row, d_col}), 32'({1'b1, 9'd479, 10'd639}));
    goto(29585); chk("d_av_after_last", 32'(d_av), 32'd0);

    // en low in the small DUTs' active area: pipeline drains with de=0
    goto(29646); en = 1'b0;
    goto(29647); chk("en_s0_de_drain0", 32'(s0_de), 32'd1);
    goto(29648);
    chk("en_s0_de_drained", 32'(s0_de), 32'd0);
    chk("en_s0_av", 32'(s0_av), 32'd0);
    goto(29650); chk("en_s3_de_drain0", 32'(s3_de), 32'd1);
    goto(29651); chk("en_s3_de_drained", 32'(s3_de), 32'd0);
    goto(29670);
    chk("en_s0_hs_hold", 32'(s0_hs), 32'd1);
    en = 1'b1;
    goto(29672);
    chk("en_s0_resume_de", 32'(s0_de), 32'd1);
    chk("en_s0_resume_rgb", 32'({s0_r, s0_g, s0_b}), 32'hF00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
